key_accumulator: RTL and testbench
==================================

# key_accumulator

Signed running-total accumulator that produces the integer shown on the four seven-segment digits. It sits directly upstream of the display-formatting stage: its DIG_Out feeds that stage's DIG_In. The operand comes from slide switches and the operation from pushbuttons, which are synchronized and debounced so that one physical press is applied exactly once. The result saturates to the displayable range: -999..9999, because a minus sign consumes one digit.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required for a press or a release (10 ms at 50 MHz).
- MAX_VAL, 9999: upper saturation bound.
- MIN_VAL, -999: lower saturation bound.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- KEY_n  in  3  raw pushbuttons, active-low, asynchronous. [0] add, [1] subtract, [2] clear.
- SW_In  in  8  unsigned operand 0..255, asynchronous.
- DIG_Out  out  32  signed running total, two's complement, always within MIN_VAL..MAX_VAL.
- Upd_Out  out  1  one-cycle pulse in the first cycle a new DIG_Out value is visible.
- Sat_Out  out  1  sticky flag: set when any operation clamped; cleared only by clear or rst.

## Operation
- KEY_n and SW_In each pass through a 2-flop synchronizer. All logic below uses only the synchronized copies. Key "pressed" means the synchronized bit is 0.
- FSM states are IDLE, DEBOUNCE, APPLY and WAIT_REL. Reset enters WAIT_REL, so a key held through reset is never applied.
- IDLE: if any key is pressed, latch one of them with priority clear > sub > add. Load the counter with DEBOUNCE_CYCLES-1 and go to DEBOUNCE.
- DEBOUNCE: this state watches only the latched key.
  - Key still pressed and counter = 0: go to APPLY.
  - Key still pressed and counter ≠ 0: decrement the counter.
  - Key released: go to IDLE with no effect.
- APPLY (exactly one cycle): compute the next value in 34-bit signed arithmetic.
  - add: DIG_Out + SW.
  - sub: DIG_Out − SW.
  - clear: 0, and Sat_Out is also cleared.
  - If the result is > MAX_VAL, register MAX_VAL and set Sat_Out. If it is < MIN_VAL, register MIN_VAL and set Sat_Out.
  - After APPLY, go to WAIT_REL.
- WAIT_REL: the counter reloads whenever any key is pressed. When all keys have been released for DEBOUNCE_CYCLES consecutive cycles, go to IDLE.
- The SW value used is the synchronized SW sampled in the APPLY cycle.
- Upd_Out pulses after every APPLY, including when the value is unchanged (for example, add 0 or an add already at MAX_VAL).
- A second key pressed during DEBOUNCE or WAIT_REL is ignored. It is not queued.

## Timing
- Reset values: DIG_Out = 0, Upd_Out = 0, Sat_Out = 0, FSM = WAIT_REL, counter = DEBOUNCE_CYCLES-1.
- Input synchronizer latency: 2 cycles.
- Let cycle P be the first IDLE cycle that sees the synchronized press.
  - DEBOUNCE occupies cycles P+1 .. P+DEBOUNCE_CYCLES.
  - APPLY occurs at cycle P+DEBOUNCE_CYCLES+1.
  - DIG_Out, Sat_Out and Upd_Out=1 appear at cycle P+DEBOUNCE_CYCLES+2.
- Upd_Out is high for exactly one cycle.
- Maximum throughput: one operation per press-and-release, at least 2·DEBOUNCE_CYCLES+2 cycles apart.
- rst asserted in any state, including APPLY, takes priority over any pending update. The next cycle shows the reset values.

## Structure
- Shared package (key_accumulator_pkg) holds:
  - the state enum {IDLE, DEBOUNCE, APPLY, WAIT_REL};
  - the op enum {OP_ADD, OP_SUB, OP_CLR};
  - the default bound constants, reused by the display stage for range checks.
- Sub-module key_sync: parameterized-width 2-flop synchronizer. Instantiated once for KEY_n (width 3) and once for SW_In (width 8).
- Counter width: $clog2(DEBOUNCE_CYCLES).

## Test plan
Simulate with DEBOUNCE_CYCLES = 4.
1. Reset, then release all keys for 6 cycles. With SW = 25, hold add for 8 cycles and release → DIG_Out = 25, one Upd_Out pulse, Sat_Out = 0.
2. With SW = 200, do 5 sub presses starting from 0 → -200, -400, -600, -800, -999. Sat_Out becomes 1 on the fifth press.
3. Clear press → DIG_Out = 0 and Sat_Out = 0. Then add with SW = 255 repeated 40 times → saturates at 9999 with Sat_Out = 1. Every press pulses Upd_Out.
4. Add pressed for only 3 cycles (bounce), repeated → DIG_Out unchanged, no Upd_Out.
5. Add and clear pressed in the same cycle, with DIG_Out = 50 → clear wins, DIG_Out = 0. A sub pressed while add is still held → ignored.
6. Assert rst in the APPLY cycle with the key held through reset → DIG_Out = 0. No update occurs until the key is released and pressed again.

Source files
------------

// File: rtl/key_accumulator_pkg.sv
// Shared types and default bounds for the key accumulator and its display stage.
package key_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    APPLY    = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_CLR = 2'd2
  } op_e;

  // Displayable range on four digits: a minus sign consumes one digit.
  localparam int          DISP_MAX_VAL            = 9999;
  localparam int          DISP_MIN_VAL            = -999;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Arithmetic width wide enough that add/sub of a 32-bit total never wraps.
  localparam int unsigned ACC_W = 34;

  // Pressed mask (1 = pressed) to operation, priority clear > sub > add.
  function automatic op_e pick_op(input logic [2:0] pressed);
    op_e op;
    if (pressed[2])      op = OP_CLR;
    else if (pressed[1]) op = OP_SUB;
    else                 op = OP_ADD;
    return op;
  endfunction

endpackage

// File: rtl/key_accumulator_sync.sv
// key_sync: parameterized-width 2-flop synchronizer for asynchronous inputs.
//   clk, rst : clock, synchronous active-high reset (loads RST_VAL)
//   d_i      : asynchronous input
//   q_o      : synchronized output, 2 cycles of latency
module key_sync #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_accumulator.sv
// key_accumulator: debounced pushbutton add/sub/clear of a switch operand into
// a signed running total saturated to MIN_VAL..MAX_VAL.
//   clk, rst : clock, synchronous active-high reset
//   KEY_n    : raw active-low keys, [0] add, [1] sub, [2] clear
//   SW_In    : raw unsigned operand
//   DIG_Out  : signed running total
//   Upd_Out  : one-cycle pulse when a new DIG_Out becomes visible
//   Sat_Out  : sticky clamp flag, cleared by clear or rst
module key_accumulator
  import key_accumulator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int          MAX_VAL         = DISP_MAX_VAL,
  parameter int          MIN_VAL         = DISP_MIN_VAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         KEY_n,
  input  logic [7:0]         SW_In,
  output logic signed [31:0] DIG_Out,
  output logic               Upd_Out,
  output logic               Sat_Out
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_VAL);
  localparam logic signed [ACC_W-1:0] MIN_ACC = ACC_W'(MIN_VAL);

  logic [2:0] key_s;
  logic [7:0] sw_s;
  logic [2:0] pressed;
  logic       any_pressed;
  logic       latched_pressed;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e op_q, op_d;
  logic signed [31:0] dig_q, dig_d;
  logic sat_q, sat_d;
  logic upd_q, upd_d;

  logic signed [ACC_W-1:0] acc_ext;
  logic signed [ACC_W-1:0] sw_ext;
  logic signed [ACC_W-1:0] result;

  // Keys reset to released so nothing looks pressed while the synchronizer refills.
  key_sync #(.WIDTH(3), .RST_VAL(3'b111)) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d_i (KEY_n),
    .q_o (key_s)
  );

  key_sync #(.WIDTH(8), .RST_VAL(8'h00)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d_i (SW_In),
    .q_o (sw_s)
  );

  assign pressed     = ~key_s;
  assign any_pressed = |pressed;

  // Debounce tracks only the key that was latched on entry.
  always_comb begin
    case (op_q)
      OP_ADD:  latched_pressed = pressed[0];
      OP_SUB:  latched_pressed = pressed[1];
      default: latched_pressed = pressed[2];
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_REL;
      cnt_q   <= CNT_MAX;
      op_q    <= OP_ADD;
      dig_q   <= '0;
      sat_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dig_q   <= dig_d;
      sat_q   <= sat_d;
      upd_q   <= upd_d;
    end
  end

  // Next-state: press latch, debounce count, release wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (any_pressed) begin
          op_d    = pick_op(pressed);
          cnt_d   = CNT_MAX;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!latched_pressed)   state_d = IDLE;
        else if (cnt_q == '0)   state_d = APPLY;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      APPLY: begin
        cnt_d   = CNT_MAX;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        // Any key activity restarts the release window.
        if (any_pressed)        cnt_d   = CNT_MAX;
        else if (cnt_q == '0)   state_d = IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = WAIT_REL;
    endcase
  end

  // Output: saturating arithmetic applied in the single APPLY cycle.
  always_comb begin
    dig_d   = dig_q;
    sat_d   = sat_q;
    upd_d   = 1'b0;
    acc_ext = ACC_W'(dig_q);
    sw_ext  = ACC_W'(sw_s);
    result  = (op_q == OP_SUB) ? (acc_ext - sw_ext) : (acc_ext + sw_ext);
    if (state_q == APPLY) begin
      upd_d = 1'b1;
      if (op_q == OP_CLR) begin
        dig_d = '0;
        sat_d = 1'b0;
      end else if (result > MAX_ACC) begin
        dig_d = 32'(MAX_VAL);
        sat_d = 1'b1;
      end else if (result < MIN_ACC) begin
        dig_d = 32'(MIN_VAL);
        sat_d = 1'b1;
      end else begin
        dig_d = 32'(result);
      end
    end
  end

  assign DIG_Out = dig_q;
  assign Upd_Out = upd_q;
  assign Sat_Out = sat_q;

endmodule

// File: tb/tb_key_accumulator.sv
// Randomized self-checking bench for key_accumulator with DEBOUNCE_CYCLES = 4.
module tb_key_accumulator;

  localparam int DEB     = 4;
  localparam int MAXV    = 9999;
  localparam int MINV    = -999;
  localparam int LATENCY = DEB + 4;  // key edge to Upd_Out: 2 sync + 1 idle + DEB + 1 apply

  logic               clk;
  logic               rst;
  logic [2:0]         KEY_n;
  logic [7:0]         SW_In;
  logic signed [31:0] DIG_Out;
  logic               Upd_Out;
  logic               Sat_Out;

  int errors;
  int checks;
  int exp_dig;
  int exp_sat;

  key_accumulator #(
    .DEBOUNCE_CYCLES (DEB),
    .MAX_VAL         (MAXV),
    .MIN_VAL         (MINV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .KEY_n   (KEY_n),
    .SW_In   (SW_In),
    .DIG_Out (DIG_Out),
    .Upd_Out (Upd_Out),
    .Sat_Out (Sat_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one accepted press changes the total by the operation rules.
  task automatic model_apply(input logic [2:0] mask, input int sw);
    int r;
    if (mask[2]) begin
      exp_dig = 0;
      exp_sat = 0;
    end else begin
      r = mask[1] ? exp_dig - sw : exp_dig + sw;
      if (r > MAXV) begin
        r = MAXV;
        exp_sat = 1;
      end else if (r < MINV) begin
        r = MINV;
        exp_sat = 1;
      end
      exp_dig = r;
    end
  endtask

  // Press 'mask' for 'hold' clock edges (optionally adding late_mask at cycle
  // late_at), release everything and let the unit settle back to idle.
  task automatic do_press(input string tag, input logic [2:0] mask, input int hold,
                          input logic [2:0] late_mask, input int late_at,
                          input logic [7:0] sw);
    int  upd_cnt;
    int  first_upd;
    int  win;
    bit  applies;
    upd_cnt   = 0;
    first_upd = -1;
    win       = hold + 3 * DEB + 8;
    applies   = (hold >= DEB + 1);
    SW_In     = sw;
    KEY_n     = ~mask;
    for (int c = 1; c <= win; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (Upd_Out) begin
        upd_cnt++;
        if (first_upd < 0) first_upd = c;
      end
      if (c == late_at && c < hold) KEY_n = KEY_n & ~late_mask;
      if (c == hold) KEY_n = 3'b111;
    end
    if (applies) model_apply(mask, int'(sw));
    check({tag, "_upd_cnt"}, upd_cnt, applies ? 1 : 0);
    if (applies) check({tag, "_latency"}, first_upd, LATENCY);
    check({tag, "_dig"}, DIG_Out, exp_dig);
    check({tag, "_sat"}, 32'(Sat_Out), exp_sat);
  endtask

  initial begin
    int upd_cnt;
    logic [2:0] m;
    logic [2:0] lm;
    int h;
    int la;
    errors  = 0;
    checks  = 0;
    exp_dig = 0;
    exp_sat = 0;
    rst     = 1'b1;
    KEY_n   = 3'b111;
    SW_In   = 8'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dig", DIG_Out, 0);
    check("reset_upd", 32'(Upd_Out), 0);
    check("reset_sat", 32'(Sat_Out), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single add.
    do_press("add25", 3'b001, 8, 3'b000, 0, 8'd25);

    // Subtract down into negative saturation.
    do_press("clr0", 3'b100, 8, 3'b000, 0, 8'd0);
    for (int i = 0; i < 5; i++) do_press("sub200", 3'b010, 8, 3'b000, 0, 8'd200);
    check("sub_floor", DIG_Out, MINV);

    // Clear then saturate upward.
    do_press("clr1", 3'b100, 8, 3'b000, 0, 8'd0);
    for (int i = 0; i < 40; i++) do_press("add255", 3'b001, 6, 3'b000, 0, 8'd255);
    check("add_ceiling", DIG_Out, MAXV);
    do_press("add0_at_max", 3'b001, 5, 3'b000, 0, 8'd0);

    // Bounces shorter than the debounce window.
    for (int i = 0; i < 3; i++) do_press("bounce3", 3'b001, 3, 3'b000, 0, 8'd9);
    do_press("bounce4", 3'b001, 4, 3'b000, 0, 8'd9);
    do_press("edge5", 3'b010, 5, 3'b000, 0, 8'd9);

    // Simultaneous add+clear, and a late sub while add is held.
    do_press("clr2", 3'b100, 8, 3'b000, 0, 8'd0);
    do_press("add50", 3'b001, 8, 3'b000, 0, 8'd50);
    do_press("add_clr", 3'b101, 8, 3'b000, 0, 8'd33);
    do_press("late_sub", 3'b001, 10, 3'b010, 3, 8'd17);
    do_press("late_rel", 3'b010, 12, 3'b100, 8, 8'd5);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      m  = 3'($urandom_range(1, 7));
      h  = $urandom_range(1, 11);
      lm = 3'b000;
      la = 0;
      if (h >= DEB + 1 && $urandom_range(0, 1) == 1) begin
        lm = 3'($urandom_range(1, 7));
        la = $urandom_range(2, h - 1);
      end
      do_press("rand", m, h, lm, la, 8'($urandom_range(0, 255)));
    end

    // Reset in the APPLY cycle with the key held through reset.
    do_press("pre_rst", 3'b001, 8, 3'b000, 0, 8'd77);
    SW_In   = 8'd10;
    KEY_n   = 3'b110;
    upd_cnt = 0;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (Upd_Out) upd_cnt++;
      if (c == 7) rst = 1'b1;
      if (c == 8) begin
        rst     = 1'b0;
        exp_dig = 0;
        exp_sat = 0;
        check("rst_apply_dig", DIG_Out, exp_dig);
        check("rst_apply_sat", 32'(Sat_Out), exp_sat);
      end
      if (c == 20) KEY_n = 3'b111;
    end
    check("rst_apply_no_upd", upd_cnt, 0);
    check("rst_apply_dig_after", DIG_Out, exp_dig);
    do_press("post_rst_add", 3'b001, 7, 3'b000, 0, 8'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
